ball_ctl: RTL

- Generates the ball position (x_pos, y_pos) that feeds collision_detector.
- Consumes its collision_det vector to reverse vertical direction.
- Handles wall and paddle bounces, ball loss, lives and game-over.
- Advances once per frame tick in the pclk domain.

---
 rtl/ball_ctl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ball_ctl.sv
// ball_ctl: ball position, bounce, loss and lives controller.
// The ball moves by SPEED pixels per axis on each frame tick.
// Block hits come from collision_detector, and the ball also bounces off the
// top wall, the side walls and the paddle. A lost ball costs a life.
module ball_ctl #(
    parameter int SPEED       = 1,
    parameter int RADIUS      = 10,
    parameter int X_MAX       = 1023,
    parameter int Y_LOST      = 756,
    parameter int PADDLE_Y    = 700,
    parameter int PADDLE_W    = 128,
    parameter int COOLDOWN    = 4,
    parameter int LOST_FRAMES = 60,
    parameter int LIVES       = 3
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        launch,
    input  logic [11:0] paddle_x,
    input  logic [15:0] collision_det,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        ball_lost,
    output logic [1:0]  lives,
    output logic        game_over
);

    // 13-bit working width, so that sums of 12-bit positions never wrap
    localparam logic [12:0] SPD      = 13'(SPEED);
    localparam logic [12:0] RAD      = 13'(RADIUS);
    localparam logic [12:0] X_HI     = 13'(X_MAX - RADIUS);
    localparam logic [12:0] TURN_L   = 13'(RADIUS + SPEED);
    localparam logic [12:0] TURN_R   = 13'(X_MAX - RADIUS - SPEED);
    localparam logic [12:0] Y_TOP    = 13'(RADIUS + SPEED);
    localparam logic [12:0] PAD_HIT  = 13'(PADDLE_Y - SPEED);
    localparam logic [12:0] PAD_Y    = 13'(PADDLE_Y);
    localparam logic [12:0] PAD_W    = 13'(PADDLE_W);
    localparam logic [12:0] HALF_W   = 13'(PADDLE_W / 2);
    localparam logic [12:0] LOST_Y   = 13'(Y_LOST);
    localparam logic [11:0] SERVE_Y  = 12'(PADDLE_Y - RADIUS);
    localparam logic [7:0]  COOL_INI = 8'(COOLDOWN);
    localparam logic [15:0] LOST_END = 16'(LOST_FRAMES - 1);
    localparam logic [1:0]  LIVES_IN = 2'(LIVES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOST, S_OVER} state_t;

    state_t      state, state_n;
    logic        dx_right, dx_n;
    logic        dy_down, dy_n;
    logic [7:0]  cool, cool_n;
    logic        coll_pend, pend_n;
    logic [15:0] lost_cnt, cnt_n;
    logic [11:0] x_n, y_n;
    logic [1:0]  lives_n;
    logic        lost_n, over_n;
    logic        hit, pend_eff, nd, nr;
    logic [12:0] ny;

    // Serve position above the paddle centre, kept inside the right wall
    function automatic logic [11:0] track_x(input logic [11:0] px);
        logic [12:0] s;
        s = {1'b0, px} + HALF_W;
        if (s > X_HI) s = X_HI;
        return s[11:0];
    endfunction

    // One horizontal step, held inside [RADIUS, X_MAX-RADIUS]
    function automatic logic [11:0] step_x(input logic [11:0] x, input logic right);
        logic [12:0] s;
        if (right) begin
            s = {1'b0, x} + SPD;
            if (s > X_HI) s = X_HI;
        end else if ({1'b0, x} < RAD + SPD) begin
            s = RAD;
        end else begin
            s = {1'b0, x} - SPD;
        end
        return s[11:0];
    endfunction

    // One vertical step; upward motion stops at RADIUS, downward is left
    // unclamped here so the caller can detect the loss line
    function automatic logic [12:0] step_y(input logic [11:0] y, input logic down);
        logic [12:0] s;
        if (down)                        s = {1'b0, y} + SPD;
        else if ({1'b0, y} < RAD + SPD)  s = RAD;
        else                             s = {1'b0, y} - SPD;
        return s;
    endfunction

    assign hit      = (collision_det != 16'd0) && (cool == 8'd0);
    assign pend_eff = coll_pend | hit;

    // State and datapath registers, all restored by the synchronous reset
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            x_pos     <= track_x(paddle_x);
            y_pos     <= SERVE_Y;
            dx_right  <= 1'b1;
            dy_down   <= 1'b0;
            lives     <= LIVES_IN;
            cool      <= 8'd0;
            coll_pend <= 1'b0;
            lost_cnt  <= 16'd0;
            ball_lost <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            x_pos     <= x_n;
            y_pos     <= y_n;
            dx_right  <= dx_n;
            dy_down   <= dy_n;
            lives     <= lives_n;
            cool      <= cool_n;
            coll_pend <= pend_n;
            lost_cnt  <= cnt_n;
            ball_lost <= lost_n;
            game_over <= over_n;
        end
    end

    // Next state: direction resolution, movement, loss and lives
    always_comb begin
        state_n = state;
        x_n     = x_pos;
        y_n     = y_pos;
        dx_n    = dx_right;
        dy_n    = dy_down;
        lives_n = lives;
        cool_n  = cool;
        pend_n  = 1'b0;
        cnt_n   = lost_cnt;
        lost_n  = 1'b0;
        over_n  = game_over;
        nd      = dy_down;
        nr      = dx_right;
        ny      = {1'b0, y_pos};

        case (state)
            S_IDLE: begin
                x_n = track_x(paddle_x);
                y_n = SERVE_Y;
                if (tick && launch) begin
                    state_n = S_RUN;
                    dx_n    = 1'b1;
                    dy_n    = 1'b0;
                    x_n     = step_x(track_x(paddle_x), 1'b1);
                    ny      = step_y(SERVE_Y, 1'b0);
                    y_n     = ny[11:0];
                end
            end

            S_RUN: begin
                if (!tick) begin
                    pend_n = pend_eff;
                end else begin
                    // Block hit reverses vertical direction and starts the cooldown
                    if (pend_eff) begin
                        nd     = ~dy_down;
                        cool_n = COOL_INI;
                    end else if (cool != 8'd0) begin
                        cool_n = cool - 8'd1;
                    end
                    // Top wall wins over a block hit: a single reversal only
                    if ({1'b0, y_pos} <= Y_TOP) nd = 1'b1;
                    if (nd && ({1'b0, y_pos} + RAD >= PAD_HIT) && ({1'b0, y_pos} < PAD_Y) &&
                        (paddle_x <= x_pos) && ({1'b0, x_pos} <= {1'b0, paddle_x} + PAD_W))
                        nd = 1'b0;
                    if ({1'b0, x_pos} <= TURN_L) nr = 1'b1;
                    if ({1'b0, x_pos} >= TURN_R) nr = 1'b0;

                    dx_n = nr;
                    dy_n = nd;
                    x_n  = step_x(x_pos, nr);
                    ny   = step_y(y_pos, nd);
                    if (ny >= LOST_Y) begin
                        y_n     = LOST_Y[11:0];
                        lost_n  = 1'b1;
                        if (lives != 2'd0) lives_n = lives - 2'd1;
                        state_n = S_LOST;
                        cnt_n   = 16'd0;
                        cool_n  = 8'd0;
                    end else begin
                        y_n = ny[11:0];
                    end
                end
            end

            S_LOST: begin
                if (tick) begin
                    if (lost_cnt >= LOST_END) begin
                        cnt_n = 16'd0;
                        dx_n  = 1'b1;
                        dy_n  = 1'b0;
                        if (lives != 2'd0) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_OVER;
                            over_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = lost_cnt + 16'd1;
                    end
                end
            end

            S_OVER: begin
                over_n = 1'b1;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
